// File: rtl/io_uart_periph.sv
// IO peripheral: LED register, UART TX with FIFO, optional receiver (`UART_RX_EN); tx falls 2 edges after a data write.
// A full FIFO drops further writes and sets the sticky ovf flag; rdata is combinational from IO_mem_addr.
module io_uart_periph #(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IO_mem_addr,
  input  logic [31:0] IO_mem_wdata,
  input  logic        IO_mem_wr,
  output logic [31:0] IO_mem_rdata,
  output logic [5:0]  leds,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic [13:0] word;
  logic        sel_led, sel_data, sel_stat;
  assign word     = IO_mem_addr[15:2];
  assign sel_led  = (word == 14'd1);
  assign sel_data = (word == 14'd2);
  assign sel_stat = (word == 14'd4);

  logic [AW:0]   rd_ptr_q, wr_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          empty, full, pop, push, ovf_q;
  logic [5:0]    leds_q;
  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [7:0]    rx_byte;
  logic          rx_valid, rx_ovr;

  assign empty = (rd_ptr_q == wr_ptr_q);
  assign full  = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
  // A full FIFO still accepts a byte when the transmitter frees a slot on the same edge.
  assign push  = IO_mem_wr && sel_data && (!full || pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q[AW-1:0]];
          cnt_d   = CW'(DIV - 1);
          state_d = TX_START;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (cnt_q == '0) begin
          cnt_d   = CW'(DIV - 1);
          bit_d   = 3'd0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_DATA: begin
        tx_d = shift_q[0];
        if (cnt_q == '0) begin
          cnt_d   = CW'(DIV - 1);
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q[AW-1:0]];
            cnt_d   = CW'(DIV - 1);
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      leds_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rd_ptr_q <= rd_ptr_q + (AW+1)'(pop);
      wr_ptr_q <= wr_ptr_q + (AW+1)'(push);
      if (IO_mem_wr && sel_led) leds_q <= IO_mem_wdata[5:0];
      if (IO_mem_wr && sel_data && full && !pop) ovf_q <= 1'b1;
      else if (IO_mem_wr && sel_stat && IO_mem_wdata[1]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= IO_mem_wdata[7:0];
  end

`ifdef UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e     rx_state_q, rx_state_d;
  logic [2:0]    sync_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d, rx_in;
  logic          unused_rx;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection.
  assign rx_in     = sync_q[1];
  assign unused_rx = ^{IO_mem_addr[31:16], IO_mem_addr[1:0], IO_mem_wdata[31:8]};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q;
    if (IO_mem_wr && sel_stat && IO_mem_wdata[2]) rx_valid_d = 1'b0;
    if (IO_mem_wr && sel_stat && IO_mem_wdata[3]) rx_ovr_d   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (sync_q[2] && !rx_in) begin
          rx_cnt_d   = CW'(DIV / 2 - 1);
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q != '0)  rx_cnt_d = rx_cnt_q - 1'b1;
        else if (rx_in)      rx_state_d = RX_IDLE;
        else begin
          rx_cnt_d   = CW'(DIV - 1);
          rx_bit_d   = 3'd0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          rx_cnt_d   = CW'(DIV - 1);
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      default: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else begin
          if (rx_in) begin
            rx_byte_d  = rx_shift_q;
            rx_valid_d = 1'b1;
            if (rx_valid_q) rx_ovr_d = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      sync_q     <= 3'b111;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      sync_q     <= {sync_q[1:0], uart_rx};
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;
  assign rx_ovr   = rx_ovr_q;
`else
  logic unused_rx;
  assign unused_rx = ^{uart_rx, IO_mem_addr[31:16], IO_mem_addr[1:0], IO_mem_wdata[31:8]};
  assign rx_byte   = 8'd0;
  assign rx_valid  = 1'b0;
  assign rx_ovr    = 1'b0;
`endif

  always_comb begin
    IO_mem_rdata = 32'd0;
    if (sel_led)       IO_mem_rdata = {26'd0, leds_q};
    else if (sel_data) IO_mem_rdata = {24'd0, rx_byte};
    else if (sel_stat) IO_mem_rdata = {26'd0, rx_ovr, rx_valid, ovf_q, full, empty, (state_q != TX_IDLE)};
  end

  assign leds    = leds_q;
  assign uart_tx = tx_q;
endmodule
